dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h88000000, giving the byte address of data-memory offset 0.
REQ-002 The block SHALL have parameter SIZE_BYTES, default 1024, giving the data-memory size in bytes (power of two, at least 4).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 For each master n in {0 (core LSU), 1 (debug/loader)}, the block SHALL have port mn_req_i, input, 1 bit: access request.
REQ-006 For each master n, the block SHALL have port mn_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-007 For each master n, the block SHALL have port mn_addr_i, input, 32 bits: byte address.
REQ-008 For each master n, the block SHALL have port mn_be_i, input, 4 bits: byte enables, bit k selects data byte k.
REQ-009 For each master n, the block SHALL have port mn_wdata_i, input, 32 bits: write data.
REQ-010 For each master n, the block SHALL have port mn_gnt_o, output, 1 bit: request accepted in this cycle.
REQ-011 For each master n, the block SHALL have port mn_rvalid_o, output, 1 bit: response valid, a one-cycle pulse.
REQ-012 For each master n, the block SHALL have port mn_rdata_o, output, 32 bits: read data.
REQ-013 For each master n, the block SHALL have port mn_err_o, output, 1 bit: the access failed; qualified by mn_rvalid_o.
REQ-014 The block SHALL have port mem_req_o, output, 1 bit: memory access strobe.
REQ-015 The block SHALL have port mem_we_o, output, 1 bit: memory write enable.
REQ-016 The block SHALL have port mem_addr_o, output, 32 bits: byte offset from BASE_ADDR, with bits [1:0] forced to 0.
REQ-017 The block SHALL have port mem_be_o, output, 4 bits: memory byte enables.
REQ-018 The block SHALL have port mem_wdata_o, output, 32 bits: memory write data.
REQ-019 The block SHALL have port mem_rdata_i, input, 32 bits: memory read data, valid one cycle after mem_req_o.

Function
REQ-020 Grant: gnt SHALL be combinational from the req inputs and the priority pointer; at most one gnt SHALL be high per cycle, and a grant SHALL be possible every cycle (pipelined, no idle cycle is required between accesses).
REQ-021 Arbitration: with a single requester, that master SHALL be granted; with both requesting, the master named by the priority pointer (ptr) SHALL be granted.
REQ-022 Priority update: after any grant, ptr SHALL point to the other master; with no grant, ptr SHALL hold.
REQ-023 Master protocol: a master SHALL hold req, we, addr, be and wdata stable until it receives gnt; the arbiter need not check this.
REQ-024 Range check: an access SHALL be in-range iff (addr - BASE_ADDR), computed as a 32-bit unsigned subtraction, is < SIZE_BYTES.
REQ-025 Alignment check: an access SHALL be legal iff be is one of: 4'b1111 with addr[1:0]=0; 4'b0011 or 4'b1100 equal to (4'b0011 << addr[1:0]) with addr[0]=0; or (4'b0001 << addr[1:0]).
REQ-026 Memory drive: in a grant cycle of an in-range, legal access, mem_req_o SHALL be 1 and mem_we_o, mem_be_o and mem_wdata_o SHALL be the granted master's inputs; otherwise mem_req_o and mem_we_o SHALL be 0.
REQ-027 Response latency: exactly one cycle after gnt, the granted master SHALL see rvalid=1 for one cycle, and the other master SHALL see rvalid=0.
REQ-028 Response data: rdata SHALL be mem_rdata_i for a successful read, and 0 for writes and errors.
REQ-029 Response error: err SHALL be 1 when the access was out-of-range or illegal; such accesses SHALL NOT reach memory.
REQ-030 Outputs when rvalid=0: rdata SHALL hold 0 and err SHALL hold 0.
REQ-031 Response state: the block SHALL keep one registered response slot (valid, master id, err, is_read); the slot SHALL be overwritten every cycle, so back-to-back grants produce back-to-back responses.
REQ-032 Address boundaries: BASE_ADDR+SIZE_BYTES-1 SHALL be in-range for a byte access; BASE_ADDR-1 and BASE_ADDR+SIZE_BYTES SHALL be errors; addresses that wrap below BASE_ADDR SHALL be errors through the unsigned compare.

Reset
REQ-033 While rst_i=1, the following SHALL be 0: all gnt, rvalid, rdata, err, mem_req_o, mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o.
REQ-034 While rst_i=1, ptr SHALL be 0 (master 0).
REQ-035 Reset asserted mid-operation SHALL drop any pending response; no rvalid SHALL be issued for a grant made in the cycle of or before reset.

Verification
REQ-036 Write then read: m0 writes 32'hDEADBEEF with be=1111 to 32'h88000010, then reads it -> mem_req once per access; the read gives rvalid one cycle after gnt, rdata=32'hDEADBEEF, err=0.
REQ-037 Contention: m0 and m1 request together for 4 cycles with ptr=0 -> grants alternate m0, m1, m0, m1; each rvalid goes to the matching master one cycle later.
REQ-038 Out of range: m1 reads 32'h88000400 and 32'h87FFFFFC -> gnt, mem_req_o=0, rvalid with err=1 and rdata=0.
REQ-039 Misaligned: m0 reads with addr=32'h88000002, be=1111 -> err=1, no mem_req.
REQ-040 Halfword: m0 reads with addr=32'h88000002, be=1100 -> legal, mem_addr_o=0, mem_be_o=1100.
REQ-041 Reset mid-operation: rst_i pulses in the cycle after a grant -> no rvalid, ptr=0, all outputs 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: alternating priority, range/alignment check,
// one-cycle pipelined response slot.
module dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR  = 32'h88000000,
  parameter int unsigned SIZE_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [31:0] SIZE_W = 32'(SIZE_BYTES);

  logic        ptr;
  logic        rsp_valid;
  logic        rsp_id;
  logic        rsp_err;
  logic        rsp_read;

  logic [1:0]  gnt;
  logic        any_gnt;
  logic        sel;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [3:0]  sel_be;
  logic [31:0] sel_wdata;
  logic [31:0] offset;
  logic [1:0]  lo;
  logic        in_range;
  logic        legal;
  logic        access_ok;

  // Grant selection and access qualification for the winning master.
  always_comb begin
    gnt = 2'b00;
    if (!rst_i) begin
      if (m0_req_i && m1_req_i) gnt = ptr ? 2'b10 : 2'b01;
      else                      gnt = {m1_req_i, m0_req_i};
    end
    any_gnt   = |gnt;
    sel       = gnt[1];
    sel_we    = sel ? m1_we_i    : m0_we_i;
    sel_addr  = sel ? m1_addr_i  : m0_addr_i;
    sel_be    = sel ? m1_be_i    : m0_be_i;
    sel_wdata = sel ? m1_wdata_i : m0_wdata_i;
    offset    = sel_addr - BASE_ADDR;
    lo        = sel_addr[1:0];
    in_range  = offset < SIZE_W;
    legal     = ((sel_be == 4'b1111) && (lo == 2'd0)) ||
                (((sel_be == 4'b0011) || (sel_be == 4'b1100)) &&
                 (sel_be == 4'(4'b0011 << lo)) && !lo[0]) ||
                (sel_be == 4'(4'b0001 << lo));
    access_ok = any_gnt && in_range && legal;
  end

  assign m0_gnt_o    = gnt[0];
  assign m1_gnt_o    = gnt[1];
  assign mem_req_o   = access_ok;
  assign mem_we_o    = access_ok && sel_we;
  assign mem_addr_o  = any_gnt ? (offset & ~32'd3) : 32'd0;
  assign mem_be_o    = any_gnt ? sel_be : 4'd0;
  assign mem_wdata_o = any_gnt ? sel_wdata : 32'd0;

  // Priority pointer and the single response slot, rewritten every cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_read  <= 1'b0;
    end else begin
      if (any_gnt) ptr <= ~sel;
      rsp_valid <= any_gnt;
      rsp_id    <= sel;
      rsp_err   <= ~(in_range && legal);
      rsp_read  <= ~sel_we;
    end
  end

  assign m0_rvalid_o = rsp_valid && !rsp_id;
  assign m1_rvalid_o = rsp_valid && rsp_id;
  assign m0_err_o    = m0_rvalid_o && rsp_err;
  assign m1_err_o    = m1_rvalid_o && rsp_err;
  assign m0_rdata_o  = (m0_rvalid_o && rsp_read && !rsp_err) ? mem_rdata_i : 32'd0;
  assign m1_rdata_o  = (m1_rvalid_o && rsp_read && !rsp_err) ? mem_rdata_i : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: attached memory device plus a
// transaction-level reference model of arbitration, checks and responses.
module tb_dmem_arbiter;

  localparam logic [31:0] BASE = 32'h88000000;
  localparam logic [31:0] SIZE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [3:0]  be    [2];
  logic [31:0] wdata [2];
  logic        gnt   [2];
  logic        rvalid[2];
  logic [31:0] rdata [2];
  logic        err   [2];
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata = 32'd0;

  logic [31:0] dev_mem [256];
  logic [31:0] shadow  [256];

  int checks = 0;
  int failures = 0;
  int ptr_m = 0;
  bit pend_v = 0;
  int pend_id = 0;
  bit pend_err = 0;
  logic [31:0] pend_rdata = 32'd0;
  int last_g = -1;

  dmem_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]), .m0_be_i(be[0]),
    .m0_wdata_i(wdata[0]), .m0_gnt_o(gnt[0]), .m0_rvalid_o(rvalid[0]),
    .m0_rdata_o(rdata[0]), .m0_err_o(err[0]),
    .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]), .m1_be_i(be[1]),
    .m1_wdata_i(wdata[1]), .m1_gnt_o(gnt[1]), .m1_rvalid_o(rvalid[1]),
    .m1_rdata_o(rdata[1]), .m1_err_o(err[1]),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory device: read data appears one cycle after the strobe, noise otherwise.
  always @(posedge clk) begin
    if (mem_req_o && !mem_we_o) begin
      mem_rdata <= dev_mem[mem_addr_o[9:2]];
    end else begin
      mem_rdata <= $urandom;
      if (mem_req_o)
        for (int k = 0; k < 4; k++)
          if (mem_be_o[k]) dev_mem[mem_addr_o[9:2]][8*k +: 8] <= mem_wdata_o[8*k +: 8];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal_m(input logic [3:0] b, input logic [1:0] lo);
    case (b)
      4'b1111, 4'b0011: return lo == 2'd0;
      4'b1100:          return lo == 2'd2;
      4'b0001:          return lo == 2'd0;
      4'b0010:          return lo == 2'd1;
      4'b0100:          return lo == 2'd2;
      4'b1000:          return lo == 2'd3;
      default:          return 1'b0;
    endcase
  endfunction

  task automatic check_zero(input string tag);
    for (int m = 0; m < 2; m++) begin
      check_val({tag, "_gnt"}, 32'(gnt[m]), 32'd0);
      check_val({tag, "_rvalid"}, 32'(rvalid[m]), 32'd0);
      check_val({tag, "_rdata"}, rdata[m], 32'd0);
      check_val({tag, "_err"}, 32'(err[m]), 32'd0);
    end
    check_val({tag, "_mem_req"}, 32'(mem_req_o), 32'd0);
    check_val({tag, "_mem_we"}, 32'(mem_we_o), 32'd0);
    check_val({tag, "_mem_addr"}, mem_addr_o, 32'd0);
    check_val({tag, "_mem_be"}, 32'(mem_be_o), 32'd0);
    check_val({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
  endtask

  // One clock cycle: check combinational and response outputs, then advance the model.
  task automatic step();
    int g;
    bit ok;
    logic [31:0] off;
    @(negedge clk); #1;
    g = -1;
    if (req[0] && req[1]) g = ptr_m;
    else if (req[0])      g = 0;
    else if (req[1])      g = 1;
    check_val("gnt0", 32'(gnt[0]), 32'(g == 0));
    check_val("gnt1", 32'(gnt[1]), 32'(g == 1));
    ok = 1'b0;
    off = 32'd0;
    if (g >= 0) begin
      off = addr[g] - BASE;
      ok = (off < SIZE) && legal_m(be[g], addr[g][1:0]);
    end
    check_val("mem_req", 32'(mem_req_o), 32'(ok));
    if (ok) begin
      check_val("mem_we", 32'(mem_we_o), 32'(we[g]));
      check_val("mem_addr", mem_addr_o, {off[31:2], 2'b00});
      check_val("mem_be", 32'(mem_be_o), 32'(be[g]));
      if (we[g]) check_val("mem_wdata", mem_wdata_o, wdata[g]);
    end else begin
      check_val("mem_we_idle", 32'(mem_we_o), 32'd0);
    end
    for (int m = 0; m < 2; m++) begin
      bit mine;
      mine = pend_v && (pend_id == m);
      check_val(m == 0 ? "rvalid0" : "rvalid1", 32'(rvalid[m]), 32'(mine));
      check_val(m == 0 ? "err0" : "err1", 32'(err[m]), 32'(mine && pend_err));
      check_val(m == 0 ? "rdata0" : "rdata1", rdata[m], mine ? pend_rdata : 32'd0);
    end
    @(posedge clk); #1;
    pend_v = (g >= 0);
    if (g >= 0) begin
      pend_id    = g;
      pend_err   = !ok;
      pend_rdata = (ok && !we[g]) ? shadow[off[9:2]] : 32'd0;
      if (ok && we[g])
        for (int k = 0; k < 4; k++)
          if (be[g][k]) shadow[off[9:2]][8*k +: 8] = wdata[g][8*k +: 8];
      ptr_m = 1 - g;
    end
    last_g = g;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_zero("rst");
    @(posedge clk); #1;
    rst = 1'b0;
    ptr_m = 0;
    pend_v = 1'b0;
    last_g = -1;
  endtask

  task automatic set_m(input int m, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    req[m] = r; we[m] = w; addr[m] = a; be[m] = b; wdata[m] = d;
  endtask

  task automatic rand_m(input int m);
    logic [31:0] word;
    logic [1:0]  lo;
    logic [3:0]  b;
    int k;
    case ($urandom % 8)
      0:       word = BASE - 32'd4;
      1:       word = BASE + SIZE;
      2:       word = BASE + SIZE - 32'd4;
      3:       word = $urandom & ~32'd3;
      default: word = BASE + (($urandom % SIZE) & ~32'd3);
    endcase
    k = int'($urandom % 4);
    case ($urandom % 4)
      0:       begin b = 4'b1111; lo = 2'd0; end
      1:       begin b = 4'(4'b0001 << k); lo = 2'(k); end
      2:       begin b = 4'(4'b0011 << (2 * (k % 2))); lo = 2'(2 * (k % 2)); end
      default: begin b = 4'($urandom); lo = 2'($urandom); end
    endcase
    set_m(m, ($urandom % 4) != 0, 1'($urandom), word | 32'(lo), b, $urandom);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = 32'd0;
      shadow[i]  = 32'd0;
    end
    set_m(0, 1'b1, 1'b0, BASE, 4'b1111, 32'd0);
    set_m(1, 1'b1, 1'b1, BASE, 4'b1111, 32'h1);
    #3;
    check_zero("por");
    @(posedge clk); #1;
    rst = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    set_m(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);

    // Write then read back.
    set_m(0, 1'b1, 1'b1, 32'h88000010, 4'b1111, 32'hDEADBEEF);
    step();
    set_m(0, 1'b1, 1'b0, 32'h88000010, 4'b1111, 32'd0);
    step();
    set_m(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    step();

    // Contention from a fresh pointer.
    do_reset();
    set_m(0, 1'b1, 1'b0, 32'h88000020, 4'b1111, 32'd0);
    set_m(1, 1'b1, 1'b0, 32'h88000010, 4'b1111, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("alternate", 32'(last_g), 32'(i % 2));
    end
    set_m(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    set_m(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    step();

    // Out of range, misaligned word, legal halfword.
    set_m(1, 1'b1, 1'b0, 32'h88000400, 4'b1111, 32'd0);
    step();
    set_m(1, 1'b1, 1'b0, 32'h87FFFFFC, 4'b1111, 32'd0);
    step();
    set_m(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    set_m(0, 1'b1, 1'b0, 32'h88000002, 4'b1111, 32'd0);
    step();
    set_m(0, 1'b1, 1'b0, 32'h88000002, 4'b1100, 32'd0);
    step();
    set_m(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    step();

    // Reset in the cycle after a grant drops the response.
    set_m(0, 1'b1, 1'b0, 32'h88000020, 4'b1111, 32'd0);
    step();
    set_m(1, 1'b1, 1'b0, 32'h88000024, 4'b1111, 32'd0);
    do_reset();
    step();
    check_val("post_rst_ptr", 32'(last_g), 32'd0);
    set_m(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    set_m(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);

    // Randomized traffic; a master keeps its request until granted.
    rand_m(0);
    rand_m(1);
    for (int i = 0; i < 3000; i++) begin
      step();
      for (int m = 0; m < 2; m++)
        if (last_g == m || !req[m]) rand_m(m);
    end
    set_m(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    set_m(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
